vdma_wr_burst_arbiter: RTL

Shares one memory-controller write-burst port between NUM_CH line-by-line input FIFO writers, e.g. several video input channels.
- Round-robin grant, one burst at a time.
- Forwards the granted channel's request, length and address to memory.
- Routes data_req and finish back to that channel only, and muxes its write data.
- Sits between the per-channel input FIFO blocks and the DDR controller, entirely in the mem_clk domain.

---
 rtl/vdma_arb_pkg.sv | 18 +
 rtl/vdma_rr_pick.sv | 38 +++
 rtl/vdma_wr_burst_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/vdma_arb_pkg.sv
// Shared types and helpers for the VDMA write-burst arbiter.
package vdma_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam int unsigned LEN_BITS_DEF = 10;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vdma_rr_pick.sv
// Combinational next-grant selection: first requester at or after the RR pointer.
// VDMA_ARB_CH0_PRIORITY_EN: channel 0 overrides the rotation whenever it requests.
module vdma_rr_pick
  import vdma_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned IW     = idx_bits(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IW-1:0]     ptr_i,
  output logic [IW-1:0]     idx_o,
  output logic              valid_o
);

  logic [IW:0] cand;

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, ptr_i} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_CH)) cand = cand - (IW+1)'(NUM_CH);
      if (!valid_o && req_i[cand[IW-1:0]]) begin
        idx_o   = cand[IW-1:0];
        valid_o = 1'b1;
      end
    end
`ifdef VDMA_ARB_CH0_PRIORITY_EN
    if (req_i[0]) begin
      idx_o   = '0;
      valid_o = 1'b1;
    end
`else
`endif
  end

endmodule

// File: rtl/vdma_wr_burst_arbiter.sv
// Round-robin arbiter sharing one DDR write-burst port among NUM_CH FIFO writers.
// Optional VDMA_ARB_CH0_PRIORITY_EN gives channel 0 absolute priority (see vdma_rr_pick).
module vdma_wr_burst_arbiter
  import vdma_arb_pkg::*;
#(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned MEM_DATA_BITS = 64,
  parameter int unsigned ADDR_BITS     = 25,
  parameter int unsigned LEN_BITS      = LEN_BITS_DEF
) (
  input  logic                            mem_clk,
  input  logic                            mem_rst_n,
  input  logic [NUM_CH-1:0]               ch_wr_burst_req,
  input  logic [NUM_CH*LEN_BITS-1:0]      ch_wr_burst_len,
  input  logic [NUM_CH*ADDR_BITS-1:0]     ch_wr_burst_addr,
  input  logic [NUM_CH*MEM_DATA_BITS-1:0] ch_wr_burst_data,
  output logic [NUM_CH-1:0]               ch_wr_burst_data_req,
  output logic [NUM_CH-1:0]               ch_wr_burst_finish,
  output logic                            mem_wr_burst_req,
  output logic [LEN_BITS-1:0]             mem_wr_burst_len,
  output logic [ADDR_BITS-1:0]            mem_wr_burst_addr,
  input  logic                            mem_wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0]        mem_wr_burst_data,
  input  logic                            mem_wr_burst_finish,
  output logic                            arb_busy,
  output logic [NUM_CH-1:0]               arb_grant
);

  localparam int unsigned IW = idx_bits(NUM_CH);

  arb_state_e              state_q;
  logic [IW-1:0]           grant_q, ptr_q, pick_idx;
  logic                    pick_valid;
  logic [LEN_BITS-1:0]     len_q;
  logic [ADDR_BITS-1:0]    addr_q;
  logic [LEN_BITS-1:0]     len_arr  [NUM_CH];
  logic [ADDR_BITS-1:0]    addr_arr [NUM_CH];
  logic [MEM_DATA_BITS-1:0] data_arr [NUM_CH];
  logic                    zero_len, gnt_req, in_xfer;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      len_arr[i]  = ch_wr_burst_len[i*LEN_BITS +: LEN_BITS];
      addr_arr[i] = ch_wr_burst_addr[i*ADDR_BITS +: ADDR_BITS];
      data_arr[i] = ch_wr_burst_data[i*MEM_DATA_BITS +: MEM_DATA_BITS];
    end
  end

  vdma_rr_pick #(
    .NUM_CH (NUM_CH),
    .IW     (IW)
  ) u_pick (
    .req_i   (ch_wr_burst_req),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign zero_len = (len_q == '0);
  assign gnt_req  = ch_wr_burst_req[grant_q];
  assign in_xfer  = (state_q == REQ) || (state_q == BURST);

  // Finish wins over data_req in REQ; a dropped request aborts without moving the pointer.
  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (pick_valid) begin
          grant_q <= pick_idx;
          len_q   <= len_arr[pick_idx];
          addr_q  <= addr_arr[pick_idx];
          state_q <= REQ;
        end
        REQ: begin
          if (zero_len || mem_wr_burst_finish) state_q <= DONE;
          else if (mem_wr_burst_data_req)      state_q <= BURST;
          else if (!gnt_req)                   state_q <= IDLE;
        end
        BURST: if (mem_wr_burst_finish) state_q <= DONE;
        DONE: begin
          ptr_q   <= (grant_q == IW'(NUM_CH - 1)) ? '0 : grant_q + IW'(1);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    ch_wr_burst_data_req          = '0;
    ch_wr_burst_finish            = '0;
    arb_grant                     = '0;
    ch_wr_burst_data_req[grant_q] = in_xfer && !zero_len && mem_wr_burst_data_req;
    ch_wr_burst_finish[grant_q]   = (in_xfer && mem_wr_burst_finish) ||
                                    ((state_q == REQ) && zero_len);
    arb_grant[grant_q]            = (state_q != IDLE);
  end

  assign mem_wr_burst_req  = (state_q == REQ) && !zero_len && gnt_req;
  assign mem_wr_burst_len  = len_q;
  assign mem_wr_burst_addr = addr_q;
  // Data mux stays combinational to keep FIFO read latency; forced to zero in reset.
  assign mem_wr_burst_data = mem_rst_n ? data_arr[grant_q] : '0;
  assign arb_busy          = (state_q != IDLE);

endmodule
